pair_lane_serializer: RTL and testbench



---
 rtl/pair_link_pkg.sv | 15 +
 rtl/pair_lane_serializer_if.sv | 30 +++
 rtl/pair_lane_serializer.sv | 128 ++++++++++++
 tb/tb_pair_lane_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_link_pkg.sv
// Shared definitions for the 2-bit pair link (serializer and deserializer ends).
//   pair_state_e    : link-end FSM states
//   PAIR_W          : bits carried per beat (O1/O2)
//   beats_per_word  : beats needed to carry an n-bit parallel word
package pair_link_pkg;

  typedef enum logic {IDLE, SEND} pair_state_e;

  localparam int PAIR_W = 2;

  function automatic int beats_per_word(input int n);
    return n / PAIR_W;
  endfunction

endpackage

// File: rtl/pair_lane_serializer_if.sv
// Handshake bundle for pair_lane_serializer.
//   word side : in_valid, in_ready, in_data[NUM_LANES]
//   beat side : O1, O2, out_valid, out_ready, out_first, out_last
//   status    : busy
// slave  : the serializer's view.
// master : the environment's view (upstream word producer plus downstream beat consumer).
interface pair_lane_serializer_if #(
  parameter int NUM_LANES = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_LANES-1:0] in_data;
  logic                 O1;
  logic                 O2;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_first;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, O1, O2, out_valid, out_first, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, O1, O2, out_valid, out_first, out_last, busy
  );
endinterface

// File: rtl/pair_lane_serializer.sv
// Transmit end of the 2-bit pair link. Takes a NUM_LANES-wide word over a
// valid/ready handshake and sends it as NUM_LANES/2 beats on O1 (even lane)
// and O2 (odd lane), lane A (bit 0) first, framed by out_first/out_last.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pair_lane_serializer_if.slave (word in, beats out, busy)
// All outputs except bus.in_ready are registered.
module pair_lane_serializer
  import pair_link_pkg::*;
#(
  parameter  int NUM_LANES  = 12,
  localparam int NBEATS     = beats_per_word(NUM_LANES),
  localparam int BEAT_CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input logic                   clk,
  input logic                   rst,
  pair_lane_serializer_if.slave bus
);

  if ((NUM_LANES < 2) || ((NUM_LANES % 2) != 0)) begin : g_bad_lanes
    $error("pair_lane_serializer: NUM_LANES must be even and >= 2");
  end

  localparam logic [BEAT_CNT_W-1:0] LAST_CNT = BEAT_CNT_W'(NBEATS - 1);

  pair_state_e            state_q, state_d;
  logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_LANES-1:0]   sh_q, sh_d, sh_nx;
  logic                   o1_q, o1_d;
  logic                   o2_q, o2_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   in_ready;
  logic                   accept;

  // Ready in IDLE, or on the final beat's handshake so the next frame
  // follows with no bubble.
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == SEND) && last_q && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // sh_q[1:0] is always the beat currently on O1/O2; the next beat is
  // taken from the shifted copy so O1/O2 stay true registers.
  assign sh_nx   = sh_q >> PAIR_W;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            o1_d    = 1'b0;
            o2_d    = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            sh_d    = sh_nx;
            o1_d    = sh_nx[0];
            o2_d    = sh_nx[1];
            cnt_d   = cnt_inc;
            first_d = 1'b0;
            last_d  = (cnt_inc == LAST_CNT);
          end
        end
      end
      default: ;
    endcase

    // A load overrides the end-of-frame return to IDLE (back-to-back case).
    if (accept) begin
      state_d = SEND;
      cnt_d   = '0;
      sh_d    = bus.in_data;
      o1_d    = bus.in_data[0];
      o2_d    = bus.in_data[1];
      first_d = 1'b1;
      last_d  = (LAST_CNT == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      o1_q    <= 1'b0;
      o2_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      first_q <= first_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.O1        = o1_q;
  assign bus.O2        = o2_q;
  assign bus.out_valid = valid_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == SEND);

endmodule

// File: tb/tb_pair_lane_serializer.sv
module tb_pair_lane_serializer;
  localparam int NL = 12;
  localparam int NB = NL / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pair_lane_serializer_if #(.NUM_LANES(NL)) bus ();
  pair_lane_serializer_if #(.NUM_LANES(2))  bus2 ();

  pair_lane_serializer #(.NUM_LANES(NL)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pair_lane_serializer #(.NUM_LANES(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;

  // beats: beat 0 in the top two bits, each beat written {O1,O2}
  typedef struct {
    logic [NL-1:0]   data;
    logic [2*NB-1:0] beats;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] beat_of(input logic [2*NB-1:0] beats, input int k);
    logic [2*NB-1:0] b;
    b = beats;
    return b[2*NB-1-2*k -: 2];
  endfunction

  // Accept one word from IDLE with out_ready=1 and check all its beats.
  task automatic run_frame(input string nm, input vec_t v);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = v.data;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = ~v.data;   // must be ignored after the accept
      #1;
      chk({nm, "_valid"}, bus.out_valid, 1);
      chk({nm, "_beat"},  {bus.O1, bus.O2}, beat_of(v.beats, k));
      chk({nm, "_first"}, bus.out_first, (k == 0));
      chk({nm, "_last"},  bus.out_last, (k == NB - 1));
      chk({nm, "_busy"},  bus.busy, 1);
    end
    @(negedge clk);
    #1;
    chk({nm, "_end_valid"}, bus.out_valid, 0);
    chk({nm, "_end_busy"},  bus.busy, 0);
    chk({nm, "_end_rdy"},   bus.in_ready, 1);
  endtask

  // Beat stream model for the random phase: {O1,O2,first,last}
  logic [3:0] mq [$];

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'hA5C, 12'b00_11_10_10_01_01};
    vecs[1] = '{12'hFFF, 12'b11_11_11_11_11_11};
    vecs[2] = '{12'h000, 12'b00_00_00_00_00_00};
    vecs[3] = '{12'h0F0, 12'b00_00_11_11_00_00};
    vecs[4] = '{12'h123, 12'b11_00_01_00_10_00};
    vecs[5] = '{12'h001, 12'b10_00_00_00_00_00};

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

    // ---- reset state
    @(negedge clk); #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_o",     {bus.O1, bus.O2}, 0);
    chk("rst_fl",    {bus.out_first, bus.out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", bus.in_ready, 1);

    // ---- table vectors, single frames
    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // ---- back-to-back FFF then 000
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 12'hFFF; bus.out_ready = 1'b1;
    for (int k = 0; k < 2 * NB; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_data = 12'h000;
      if (k == NB) bus.in_valid = 1'b0;
      #1;
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_busy",  bus.busy, 1);
      chk("b2b_beat",  {bus.O1, bus.O2}, (k < NB) ? 2'b11 : 2'b00);
      chk("b2b_first", bus.out_first, (k % NB == 0));
      chk("b2b_last",  bus.out_last, (k % NB == NB - 1));
      chk("b2b_rdy",   bus.in_ready, (k == NB - 1) || (k == 2 * NB - 1));
    end
    @(negedge clk); #1;
    chk("b2b_end_valid", bus.out_valid, 0);

    // ---- backpressure 0F0, out_ready pattern 1,0,0,1,0,0,...
    begin
      int k;
      int cyc;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = vecs[3].data; bus.out_ready = 1'b0;
      k = 0; cyc = 0;
      while (k < NB && cyc < 40) begin
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_data   = 12'hFFF;
        bus.out_ready = (cyc % 3 == 0);
        #1;
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_beat",  {bus.O1, bus.O2}, beat_of(vecs[3].beats, k));
        chk("bp_first", bus.out_first, (k == 0));
        chk("bp_last",  bus.out_last, (k == NB - 1));
        chk("bp_rdy",   bus.in_ready, (k == NB - 1) && bus.out_ready);
        if (bus.out_ready) k++;
        cyc++;
      end
      chk("bp_timeout", (k == NB), 1);
      @(negedge clk); bus.out_ready = 1'b1; #1;
      chk("bp_end_valid", bus.out_valid, 0);
    end

    // ---- input blocked while busy: 123 offered during beat 2 of A5C
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = vecs[0].data; bus.out_ready = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      bus.in_valid = (k >= 2);
      bus.in_data  = (k >= 2) ? vecs[4].data : 12'hFFF;
      #1;
      chk("blk_beat", {bus.O1, bus.O2}, beat_of(vecs[0].beats, k));
      chk("blk_rdy",  bus.in_ready, (k == NB - 1));
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("blk2_valid", bus.out_valid, 1);
      chk("blk2_beat",  {bus.O1, bus.O2}, beat_of(vecs[4].beats, k));
      chk("blk2_first", bus.out_first, (k == 0));
    end
    @(negedge clk); #1;
    chk("blk_end_valid", bus.out_valid, 0);

    // ---- reset mid-frame at beat 3
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 12'hFFF; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.in_valid = 1'b0;
    end
    @(negedge clk); #1;
    chk("mid_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_busy",  bus.busy, 0);
    chk("mid_o",     {bus.O1, bus.O2}, 0);
    chk("mid_fl",    {bus.out_first, bus.out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy", bus.in_ready, 1);
    chk("mid_rel_valid", bus.out_valid, 0);
    run_frame("post_rst", vecs[5]);

    // ---- NUM_LANES=2 instance, word 2'b10
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.in_data = 2'b10; bus2.out_ready = 1'b0;
    #1;
    chk("n2_rdy_idle", bus2.in_ready, 1);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    #1;
    chk("n2_valid", bus2.out_valid, 1);
    chk("n2_beat",  {bus2.O1, bus2.O2}, 2'b01);
    chk("n2_fl",    {bus2.out_first, bus2.out_last}, 2'b11);
    chk("n2_rdy_stall", bus2.in_ready, 0);
    @(negedge clk);
    bus2.out_ready = 1'b1;
    #1;
    chk("n2_hold", {bus2.O1, bus2.O2}, 2'b01);
    chk("n2_rdy_last", bus2.in_ready, 1);
    @(negedge clk); #1;
    chk("n2_end_valid", bus2.out_valid, 0);

    // ---- randomized traffic against a beat-queue model
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic          exp_rdy;
      logic [NL-1:0] w;
      @(negedge clk);
      if (c < 360) begin
        bus.in_valid  = $urandom_range(0, 1);
        bus.in_data   = NL'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      #1;
      exp_rdy = (mq.size() == 0) || ((mq.size() == 1) && bus.out_ready);
      chk("rnd_valid", bus.out_valid, (mq.size() != 0));
      chk("rnd_rdy",   bus.in_ready, exp_rdy);
      if (bus.out_ready && mq.size() != 0) begin
        logic [3:0] e;
        e = mq.pop_front();
        chk("rnd_beat", {bus.O1, bus.O2, bus.out_first, bus.out_last}, e);
      end
      if (bus.in_valid && exp_rdy) begin
        w = bus.in_data;
        for (int k = 0; k < NB; k++)
          mq.push_back({w[2*k], w[2*k+1], (k == 0), (k == NB - 1)});
      end
    end
    chk("rnd_drained", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
